bin_a_bcd_secuencial: RTL



---
 rtl/bin_a_bcd_secuencial.sv | 92 +++++++++
 1 files changed

// File: rtl/bin_a_bcd_secuencial.sv
// Sequential binary-to-BCD converter (shift-and-add-3).
// Level init starts a conversion; done is held until init drops.
module bin_a_bcd_secuencial #(
  parameter int N_BITS   = 32,
  parameter int N_DIGITS = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  init,
  input  logic [N_BITS-1:0]     bin_in,
  output logic [4*N_DIGITS-1:0] bcd_out,
  output logic                  busy,
  output logic                  done
);

  localparam int W  = 4 * N_DIGITS;
  localparam int CW = $clog2(N_BITS + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ADJUST = 2'd1,
    SHIFT  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [N_BITS-1:0] bin_sh;
  logic [W-1:0]      bcd_acc;
  logic [W-1:0]      adj;
  logic [CW-1:0]     cnt;
  logic              last;

  assign last = (cnt == CW'(1));
  assign busy = (state == ADJUST) || (state == SHIFT);
  assign done = (state == DONE);

  always_comb begin
    adj = bcd_acc;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (bcd_acc[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = bcd_acc[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = IDLE;
    case (state)
      IDLE:    state_nx = init ? ADJUST : IDLE;
      ADJUST:  state_nx = SHIFT;
      SHIFT:   state_nx = last ? DONE : ADJUST;
      DONE:    state_nx = init ? DONE : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_sh  <= '0;
      bcd_acc <= '0;
      cnt     <= '0;
      bcd_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (init) begin
            bin_sh  <= bin_in;
            bcd_acc <= '0;
            cnt     <= CW'(N_BITS);
          end
        end
        ADJUST: bcd_acc <= adj;
        SHIFT: begin
          {bcd_acc, bin_sh} <= {bcd_acc[W-2:0], bin_sh, 1'b0};
          cnt <= cnt - CW'(1);
          // result is the accumulator after this final shift
          if (last)
            bcd_out <= {bcd_acc[W-2:0], bin_sh[N_BITS-1]};
        end
        default: ;
      endcase
    end
  end

endmodule
